// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller beside M: SR/Cause/EPC/PRId, mtc0/mfc0, eret, flush request.
// Optional macro CP0_EPC_FWD_EN: epc_out forwards a same-cycle EPC write or capture.
module cp0_ctrl #(
    parameter logic [31:0] PRID       = 32'h2023_0701,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc_in,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret_in,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [31:2] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_cap;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    // Victim PC: a delay-slot instruction restarts at its branch.
    assign epc_cap = bd_in ? (vpc_in - 32'd4) : vpc_in;

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
    assign epc_val   = {epc_q, 2'b00};

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (req) begin
            exl_d = 1'b1;
            exc_d = int_req ? 5'd0 : exc_code_in;
            bd_d  = bd_in;
            epc_d = epc_cap[31:2];
        end else if (eret_in) begin
            exl_d = 1'b0;
        end else if (en) begin
            case (cp0_addr)
                5'd12: begin
                    im_d  = cp0_wdata[15:10];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                5'd14:   epc_d = cp0_wdata[31:2];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= hw_int;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        case (cp0_addr)
            5'd12:   cp0_rdata = sr_val;
            5'd13:   cp0_rdata = cause_val;
            5'd14:   cp0_rdata = epc_val;
            5'd15:   cp0_rdata = PRID;
            default: cp0_rdata = 32'd0;
        endcase
    end

`ifdef CP0_EPC_FWD_EN
    always_comb begin
        epc_out = epc_val;
        if (req)
            epc_out = {epc_cap[31:2], 2'b00};
        else if (en && (cp0_addr == 5'd14))
            epc_out = {cp0_wdata[31:2], 2'b00};
    end
`else
    assign epc_out = epc_val;
`endif

    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl with hand-computed expectations.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret_in;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int checks   = 0;
    int failures = 0;

    cp0_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc_in      (vpc_in),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .eret_in     (eret_in),
        .hw_int      (hw_int),
        .req         (req),
        .epc_out     (epc_out),
        .handler_pc  (handler_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick();
        en = 1'b0; cp0_wdata = '0;
    endtask

    task automatic eret();
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cp0_addr = '0; cp0_wdata = '0;
        vpc_in = '0; bd_in = 1'b0; exc_code_in = '0; eret_in = 1'b0; hw_int = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h2023_0701);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_epc_out", epc_out, 32'h0);
        chk("handler_pc", handler_pc, 32'h0000_4180);

        // Interrupt path
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; vpc_in = 32'h0000_2000; bd_in = 1'b0;
        #1;
        chk("int_req", {31'd0, req}, 32'd1);
        tick();
        chk("int_masked", {31'd0, req}, 32'd0);
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_2000);
        chk("int_epc_out", epc_out, 32'h0000_2000);
        hw_int = '0;
        eret();
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // Exception in delay slot
        exc_code_in = 5'd4; bd_in = 1'b1; vpc_in = 32'h0000_3010;
        #1;
        chk("adel_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = '0; bd_in = 1'b0;
        rd("adel_cause", 5'd13, 32'h8000_0010);
        rd("adel_epc", 5'd14, 32'h0000_300C);

        // Masked while EXL, then unmasked after eret
        exc_code_in = 5'd10;
        #1;
        chk("exl_mask_req", {31'd0, req}, 32'd0);
        tick();
        rd("exl_mask_cause", 5'd13, 32'h8000_0010);
        exc_code_in = '0;
        eret();
        exc_code_in = 5'd10; vpc_in = 32'h0000_5000;
        #1;
        chk("post_eret_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = '0;
        rd("ri_cause", 5'd13, 32'h0000_0028);
        rd("ri_epc", 5'd14, 32'h0000_5000);
        eret();

        // mtc0 EPC: same-cycle epc_out and read-after-write
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3107;
        #1;
        chk("raw_old_rdata", cp0_rdata, 32'h0000_5000);
`ifdef CP0_EPC_FWD_EN
        chk("fwd_epc_out", epc_out, 32'h0000_3104);
`else
        chk("nofwd_epc_out", epc_out, 32'h0000_5000);
`endif
        tick();
        en = 1'b0;
        rd("raw_new_rdata", 5'd14, 32'h0000_3104);
        chk("epc_out_new", epc_out, 32'h0000_3104);

        // req beats mtc0 and eret in the same cycle
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0; eret_in = 1'b1;
        exc_code_in = 5'd12; vpc_in = 32'h0000_6002;
        #1;
        chk("prio_req", {31'd0, req}, 32'd1);
        tick();
        en = 1'b0; eret_in = 1'b0; exc_code_in = '0;
        rd("prio_sr", 5'd12, 32'h0000_0403);
        rd("prio_cause", 5'd13, 32'h0000_0030);
        rd("prio_epc", 5'd14, 32'h0000_6000);
        eret();

        // vpc_in-4 wraps
        exc_code_in = 5'd1; bd_in = 1'b1; vpc_in = 32'h0000_0002;
        tick();
        exc_code_in = '0; bd_in = 1'b0;
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0004);
        eret();

        // Interrupt wins over simultaneous exception
        hw_int = 6'b000001; exc_code_in = 5'd5; vpc_in = 32'h0000_7000;
        tick();
        exc_code_in = '0;
        rd("both_cause", 5'd13, 32'h0000_0400);
        rd("both_epc", 5'd14, 32'h0000_7000);
        hw_int = '0;

        // Reset with EXL set and a pending exception
        exc_code_in = 5'd3; reset = 1'b1;
        tick();
        reset = 1'b0; exc_code_in = '0;
        rd("rst2_sr", 5'd12, 32'h0);
        rd("rst2_cause", 5'd13, 32'h0);
        chk("rst2_epc_out", epc_out, 32'h0);

        // Read-only / unmapped writes and SR field masking
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0);
        mtc0(5'd15, 32'h1234_5678);
        rd("prid_ro", 5'd15, 32'h2023_0701);
        mtc0(5'd5, 32'hDEAD_BEEF);
        rd("unmapped", 5'd5, 32'h0);
        mtc0(5'd12, 32'hFFFF_FFFE);
        rd("sr_mask", 5'd12, 32'h0000_FC02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
